// File: rtl/scan_pkg.sv
// Shared types and helpers for the raster scan sequencer: FSM states,
// width helper and end-of-frame position constants.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

  localparam int SCAN_WIDTH    = 32;
  localparam int SCAN_HEIGHT   = 32;
  localparam int SCAN_LAST_COL = SCAN_WIDTH - 1;
  localparam int SCAN_LAST_ROW = SCAN_HEIGHT - 1;

  // Never returns zero so a one-position axis still gets a 1-bit port
  function automatic int safe_clog2(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int frame_last(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/scan_gap_timer.sv
// Loadable down-counter; tc goes high once the loaded count has run out
// and stays high until the next load.
module scan_gap_timer
  import scan_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Count down towards zero; tc is registered alongside the count
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
      tc      <= 1'b0;
    end else if (load) begin
      count_r <= load_value;
      tc      <= (load_value == {W{1'b0}});
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - ONE;
      tc      <= (count_r == ONE);
    end else begin
      count_r <= count_r;
      tc      <= 1'b1;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Frame-level controller for the raster row/column counter: runs a
// requested number of scans with a reset gap between frames.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter  int WIDTH      = SCAN_WIDTH,
  parameter  int HEIGHT     = SCAN_HEIGHT,
  parameter  int FRAME_W    = 8,
  parameter  int GAP_CYCLES = 4,
  localparam int CW         = safe_clog2(WIDTH),
  localparam int RW         = safe_clog2(HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic               abort,
  input  logic               stall,
  input  logic [CW-1:0]      column_counter,
  input  logic [RW-1:0]      row_counter,
  output logic               cnt_rst,
  output logic               cnt_enable,
  output logic               busy,
  output logic               frame_start,
  output logic               frame_done,
  output logic               seq_done,
  output logic [FRAME_W-1:0] frame_index
);

  localparam int                 GW        = safe_clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0]      LAST_COL  = CW'(frame_last(WIDTH));
  localparam logic [RW-1:0]      LAST_ROW  = RW'(frame_last(HEIGHT));
  localparam logic [GW-1:0]      GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

  scan_state_e        state_r;
  logic [FRAME_W-1:0] frames_r;
  logic               last_pos_s;
  logic               more_s;
  logic               gap_load_s;
  logic               gap_tc_s;

  assign cnt_enable = (state_r == ST_RUN) && !stall;

  // End-of-frame detection: the last position only counts on an enabled edge
  always_comb begin
    last_pos_s = 1'b0;
    more_s     = 1'b0;
    gap_load_s = 1'b0;
    if ((state_r == ST_RUN) && !stall &&
        (column_counter == LAST_COL) && (row_counter == LAST_ROW)) begin
      last_pos_s = 1'b1;
    end else begin
      last_pos_s = 1'b0;
    end
    more_s     = (frame_index < (frames_r - FRAME_ONE));
    gap_load_s = last_pos_s && more_s && !abort;
  end

  scan_gap_timer #(.W(GW)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (gap_load_s),
    .load_value (GAP_LOAD),
    .tc         (gap_tc_s)
  );

  // Sequencer FSM with registered control outputs and event pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      frames_r    <= {FRAME_W{1'b0}};
      frame_index <= {FRAME_W{1'b0}};
      cnt_rst     <= 1'b1;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      seq_done    <= 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
        state_r <= ST_IDLE;
        cnt_rst <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && (num_frames != {FRAME_W{1'b0}})) begin
              state_r     <= ST_CLEAR;
              frames_r    <= num_frames;
              frame_index <= {FRAME_W{1'b0}};
              busy        <= 1'b1;
              cnt_rst     <= 1'b1;
            end else if (start) begin
              seq_done <= 1'b1;
            end
          end
          ST_CLEAR: begin
            state_r     <= ST_RUN;
            cnt_rst     <= 1'b0;
            frame_start <= 1'b1;
          end
          ST_RUN: begin
            if (last_pos_s) begin
              frame_done <= 1'b1;
              cnt_rst    <= 1'b1;
              if (more_s) begin
                state_r     <= ST_GAP;
                frame_index <= frame_index + FRAME_ONE;
              end else begin
                state_r  <= ST_DONE;
                seq_done <= 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (gap_tc_s) begin
              state_r     <= ST_RUN;
              cnt_rst     <= 1'b0;
              frame_start <= 1'b1;
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_rst <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomised and directed bench for scan_sequencer; a 32x32 and a 1x1
// instance share stimulus and are each tracked by a frame-level model.
module tb_scan_sequencer;

  localparam int W0 = 32, H0 = 32, G0 = 4;
  localparam int W1 = 1,  H1 = 1,  G1 = 2;
  localparam int FW = 8;
  localparam int CW0 = 5, RW0 = 5, CW1 = 1, RW1 = 1;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_GAP = 3, P_DONE = 4;

  typedef struct {
    int phase;
    int pos;
    int gap_left;
    int frames;
    int idx;
    bit fs;
    bit fd;
    bit sd;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, stall;
  logic [FW-1:0] num_frames;
  logic [CW0-1:0] col0;
  logic [RW0-1:0] row0;
  logic [CW1-1:0] col1;
  logic [RW1-1:0] row1;
  logic cnt_rst0, en0, busy0, fs0, fd0, sd0;
  logic cnt_rst1, en1, busy1, fs1, fd1, sd1;
  logic [FW-1:0] fi0, fi1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  model_t m0, m1;

  scan_sequencer #(.WIDTH(W0), .HEIGHT(H0), .FRAME_W(FW), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames), .abort(abort),
    .stall(stall), .column_counter(col0), .row_counter(row0), .cnt_rst(cnt_rst0),
    .cnt_enable(en0), .busy(busy0), .frame_start(fs0), .frame_done(fd0),
    .seq_done(sd0), .frame_index(fi0)
  );

  scan_sequencer #(.WIDTH(W1), .HEIGHT(H1), .FRAME_W(FW), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames), .abort(abort),
    .stall(stall), .column_counter(col1), .row_counter(row1), .cnt_rst(cnt_rst1),
    .cnt_enable(en1), .busy(busy1), .frame_start(fs1), .frame_done(fd1),
    .seq_done(sd1), .frame_index(fi1)
  );

  // Raster counters that sit beside each sequencer
  always @(posedge clk) begin
    if (cnt_rst0) begin
      col0 <= '0; row0 <= '0;
    end else if (en0) begin
      if (col0 == CW0'(W0 - 1)) begin
        col0 <= '0;
        row0 <= (row0 == RW0'(H0 - 1)) ? '0 : row0 + 1'b1;
      end else begin
        col0 <= col0 + 1'b1;
      end
    end
    if (cnt_rst1) begin
      col1 <= '0; row1 <= '0;
    end else if (en1) begin
      if (col1 == CW1'(W1 - 1)) begin
        col1 <= '0;
        row1 <= (row1 == RW1'(H1 - 1)) ? '0 : row1 + 1'b1;
      end else begin
        col1 <= col1 + 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Frame-level reference: positions consumed per frame, gap length, frame count
  task automatic model_step(inout model_t m, input int w, input int h, input int g);
    m.fs = 1'b0; m.fd = 1'b0; m.sd = 1'b0;
    if (!rst) begin
      m.phase = P_IDLE; m.idx = 0;
    end else if (abort && m.phase != P_IDLE) begin
      m.phase = P_IDLE;
    end else begin
      case (m.phase)
        P_IDLE:
          if (start) begin
            if (num_frames != 0) begin
              m.phase = P_CLEAR; m.frames = num_frames; m.idx = 0;
            end else begin
              m.sd = 1'b1;
            end
          end
        P_CLEAR: begin m.phase = P_RUN; m.pos = 0; m.fs = 1'b1; end
        P_RUN:
          if (!stall) begin
            m.pos++;
            if (m.pos == w * h) begin
              m.fd = 1'b1;
              if (m.idx < m.frames - 1) begin
                m.phase = P_GAP; m.idx++; m.gap_left = g;
              end else begin
                m.phase = P_DONE; m.sd = 1'b1;
              end
            end
          end
        P_GAP: begin
          m.gap_left--;
          if (m.gap_left == 0) begin m.phase = P_RUN; m.pos = 0; m.fs = 1'b1; end
        end
        default: m.phase = P_IDLE;
      endcase
    end
  endtask

  task automatic check_reg(input string tag, input model_t m, input int w,
                           input logic cr, input logic bz, input logic fs, input logic fd,
                           input logic sd, input logic [FW-1:0] fi,
                           input logic [31:0] col, input logic [31:0] row);
    chk({tag, ".busy"}, bz, m.phase != P_IDLE);
    chk({tag, ".cnt_rst"}, cr, m.phase != P_RUN);
    chk({tag, ".frame_start"}, fs, m.fs);
    chk({tag, ".frame_done"}, fd, m.fd);
    chk({tag, ".seq_done"}, sd, m.sd);
    chk({tag, ".frame_index"}, fi, m.idx);
    if (m.phase == P_RUN) begin
      chk({tag, ".col"}, col, m.pos % w);
      chk({tag, ".row"}, row, m.pos / w);
    end
  endtask

  task automatic run_cycle();
    #1;
    chk("d0.cnt_enable", en0, (m0.phase == P_RUN) && !stall);
    chk("d1.cnt_enable", en1, (m1.phase == P_RUN) && !stall);
    @(posedge clk);
    model_step(m0, W0, H0, G0);
    model_step(m1, W1, H1, G1);
    cyc++;
    #1;
    check_reg("d0", m0, W0, cnt_rst0, busy0, fs0, fd0, sd0, fi0, col0, row0);
    check_reg("d1", m1, W1, cnt_rst1, busy1, fs1, fd1, sd1, fi1, col1, row1);
    @(negedge clk);
  endtask

  task automatic wait_pos(input int r, input int c, input int bound);
    int n = 0;
    while (!(row0 == RW0'(r) && col0 == CW0'(c) && !cnt_rst0) && n < bound) begin
      run_cycle(); n++;
    end
    chk("reach_pos", (row0 == RW0'(r) && col0 == CW0'(c) && !cnt_rst0), 1);
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while ((busy0 || busy1) && n < bound) begin
      run_cycle(); n++;
    end
    chk("idle_bound", busy0 || busy1, 0);
  endtask

  task automatic pulse_start(input int nf);
    start = 1'b1; num_frames = FW'(nf);
    run_cycle();
    start = 1'b0;
  endtask

  initial begin
    int t0, n, cnt;
    int fdq[$];
    m0 = '{default: 0};
    m1 = '{default: 0};
    rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; num_frames = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    run_cycle(); run_cycle();
    rst = 1'b1;
    run_cycle();

    // single frame: seq_done with frame_done 1026 cycles after start is sampled
    t0 = cyc + 1;
    pulse_start(1);
    n = 0;
    while (!sd0 && n < 2000) begin run_cycle(); n++; end
    chk("single_latency", cyc - t0 + 1, 1026);
    chk("single_fd_with_sd", fd0, 1);
    run_until_idle(10);

    // three frames: frame_done spacing of WIDTH*HEIGHT+GAP
    pulse_start(3);
    n = 0; fdq.delete();
    while (!sd0 && n < 4000) begin
      run_cycle(); n++;
      if (fd0) fdq.push_back(cyc);
    end
    chk("three_fd_count", fdq.size(), 3);
    chk("three_last_index", fi0, 2);
    if (fdq.size() == 3) begin
      chk("three_spacing_01", fdq[1] - fdq[0], 1028);
      chk("three_spacing_12", fdq[2] - fdq[1], 1028);
    end
    cnt = 0;
    repeat (6) begin run_cycle(); if (sd0) cnt++; end
    chk("three_extra_seq_done", cnt, 0);

    // eight stalled cycles mid-row delay completion by eight
    t0 = cyc + 1;
    pulse_start(1);
    wait_pos(3, 10, 2000);
    stall = 1'b1;
    repeat (8) run_cycle();
    chk("stall_frozen_col", col0, 10);
    stall = 1'b0;
    n = 0;
    while (!sd0 && n < 2000) begin run_cycle(); n++; end
    chk("stall_latency", cyc - t0 + 1, 1034);
    run_until_idle(10);

    // stall held on the last position holds back frame_done
    pulse_start(1);
    wait_pos(31, 31, 2000);
    stall = 1'b1;
    repeat (5) begin run_cycle(); chk("last_stall_fd", fd0, 0); end
    stall = 1'b0;
    run_cycle();
    chk("last_release_fd", fd0, 1);
    run_until_idle(10);

    // abort, then reset, at row 5 column 3
    for (int k = 0; k < 2; k++) begin
      pulse_start(2);
      wait_pos(5, 3, 2000);
      if (k == 0) abort = 1'b1; else rst = 1'b0;
      run_cycle();
      abort = 1'b0; rst = 1'b1;
      chk("abort_busy", busy0, 0);
      chk("abort_cnt_rst", cnt_rst0, 1);
      cnt = 0;
      repeat (12) begin run_cycle(); if (fd0 || sd0) cnt++; end
      chk("abort_no_events", cnt, 0);
    end

    // zero frames: seq_done only
    pulse_start(0);
    chk("zero_seq_done", sd0, 1);
    chk("zero_busy", busy0, 0);
    run_cycle();
    chk("zero_busy_after", busy0, 0);

    // start during RUN is ignored
    pulse_start(2);
    wait_pos(2, 7, 2000);
    pulse_start(7);
    n = 0; cnt = 0;
    while (!sd0 && n < 4000) begin run_cycle(); n++; if (fd0) cnt++; end
    chk("ignored_start_frames", cnt, 2);
    run_until_idle(10);

    // randomised sessions
    repeat (8) begin
      pulse_start($urandom_range(0, 3));
      n = 0;
      while (busy0 && n < 5000) begin
        stall = ($urandom_range(0, 7) == 0);
        abort = ($urandom_range(0, 2999) == 0);
        start = ($urandom_range(0, 499) == 0);
        num_frames = FW'($urandom);
        run_cycle(); n++;
      end
      stall = 1'b0; abort = 1'b0; start = 1'b0;
      run_until_idle(4000);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Frame-level controller for the raster row/column counter. Drives the counter's reset and enable to run a requested number of full WIDTH×HEIGHT scans. Honours a downstream stall and inserts a fixed reset gap between frames. Reports per-frame and end-of-sequence events. Sits between the control logic that issues scan requests and the counter instance it sequences.

## Interface
- WIDTH, 32: columns per row; must match the sequenced counter.
- HEIGHT, 32: rows per frame; must match the sequenced counter.
- FRAME_W, 8: width of the frame-count fields.
- GAP_CYCLES, 4: inter-frame cycles with the counter held in reset; legal range is ≥1.
- CW, RW: local widths. CW = max(1, clog2(WIDTH)); RW = max(1, clog2(HEIGHT)).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- num_frames  in  FRAME_W  frames to run; latched when start is accepted.
- abort  in  1  terminates any active sequence.
- stall  in  1  downstream backpressure; freezes the scan.
- column_counter  in  CW  counter column position.
- row_counter  in  RW  counter row position.
- cnt_rst  out  1  active-high reset to the counter.
- cnt_enable  out  1  advance enable to the counter.
- busy  out  1  high from start acceptance until return to IDLE.
- frame_start  out  1  one-cycle pulse on the first RUN cycle of each frame.
- frame_done  out  1  one-cycle pulse after the last position of each frame.
- seq_done  out  1  one-cycle pulse when the sequence completes normally.
- frame_index  out  FRAME_W  zero-based index of the current frame.

## Operation
- Counter contract:
  - cnt_rst=1 puts the counter at (0,0) on the next edge.
  - Each edge with cnt_enable=1 advances it one position: the column wraps WIDTH-1→0 and the row increments.
  - The last position of a frame is (HEIGHT-1, WIDTH-1).
- States: IDLE, CLEAR, RUN, GAP, DONE.
- IDLE:
  - Outputs: cnt_rst=1, cnt_enable=0, busy=0.
  - start with num_frames≠0: latch num_frames, clear frame_index, go to CLEAR.
  - start with num_frames=0: pulse seq_done next cycle and stay in IDLE.
- CLEAR: one cycle with cnt_rst=1, then go to RUN.
- RUN:
  - cnt_rst=0; cnt_enable = !stall, combinational from the state register and stall.
  - Last-position condition: an edge with cnt_enable=1 while the counter reads (HEIGHT-1, WIDTH-1).
  - On that edge, go to GAP if frame_index < latched−1, otherwise go to DONE.
- GAP:
  - cnt_rst=1 for GAP_CYCLES cycles.
  - frame_index increments on GAP entry.
  - Then go to RUN.
- DONE: one cycle, then go to IDLE.
- frame_done is high in the first cycle of GAP or of DONE.
- seq_done is high in the DONE cycle.
- abort:
  - Takes priority over every other transition.
  - From any non-IDLE state, go to IDLE next edge.
  - No frame_done or seq_done is generated; cnt_rst is reasserted.
- start while busy is ignored. num_frames changes after acceptance have no effect.
- rst low:
  - State goes to IDLE, frame_index=0.
  - cnt_rst=1, cnt_enable=0, and all pulses 0.
  - Reset mid-frame behaves like abort.

## Timing
- start accepted at edge t: CLEAR is the cycle after t, and the first RUN cycle (frame_start) is the cycle after that.
- Unstalled frame: exactly WIDTH×HEIGHT RUN cycles. The last position is consumed at the end of RUN cycle WIDTH×HEIGHT.
- Single frame, no stall, default parameters: seq_done and frame_done are high together 1026 cycles after start is sampled.
- Multi-frame period: WIDTH×HEIGHT + GAP_CYCLES cycles per frame, unstalled.
- Each stalled RUN cycle extends the frame by one cycle. Stall has no effect outside RUN.
- All outputs except cnt_enable are registered.

## Structure
- Shared package scan_pkg holds:
  - the state enum;
  - the safe-clog2 function used for CW and RW;
  - the end-of-frame position constants.
- One sub-module, scan_gap_timer: a loadable down-counter with a terminal-count output, used for GAP.
- The counter itself is instantiated beside this block, not inside it.

## Test plan
- Single frame: rst deasserted, num_frames=1, start pulse. Expect frame_start on the first RUN cycle, 1024 enabled cycles, then frame_done and seq_done together 1026 cycles after start, then busy=0.
- Three frames, GAP_CYCLES=4. Expect:
  - frame_index steps 0→1→2;
  - frame_done pulses at 1028-cycle spacing;
  - cnt_rst high for 4 cycles between frames;
  - a single seq_done after frame 2.
- Stall:
  - Assert stall for 8 cycles mid-row. Expect cnt_enable=0 and the counter frozen for those 8 cycles; seq_done arrives 8 cycles later than baseline.
  - Separately, stall on the last position delays frame_done until the stall is released.
- Abort and reset: abort at row 5, column 3. Expect IDLE next cycle, cnt_rst=1, and no frame_done or seq_done. Repeat with rst low at the same point and expect the same result.
- Edge requests:
  - num_frames=0: seq_done only, busy stays 0.
  - start pulsed during RUN: ignored, frame count unchanged.
  - WIDTH=1, HEIGHT=1: one RUN cycle per frame.
